// File: rtl/memio_pkg.sv
// Shared decode constants and types for the CPU byte-bus responder.
package memio_pkg;

  localparam logic [1:0] IO_WIN      = 2'b11;
  localparam logic [2:0] IO_UART_OFS = 3'd0;
  localparam logic [2:0] IO_CNT_OFS  = 3'd4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_UNMAP,
    REG_IO
  } region_e;

  // mem_a[17:16]: 00/01 RAM, 10 hole, 11 I/O window
  function automatic region_e decode_region(input logic [1:0] sel);
    if (sel == IO_WIN)     return REG_IO;
    else if (sel == 2'b10) return REG_UNMAP;
    else                   return REG_RAM;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus bundle: CPU drives address/strobe/data, responder returns read byte and stall.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;

  modport master (output mem_a, mem_wr, mem_wdata, input mem_rdata, io_buffer_full);
  modport slave  (input mem_a, mem_wr, mem_wdata, output mem_rdata, io_buffer_full);
endinterface

// File: rtl/memio_tx_fifo.sv
// Power-of-2 byte FIFO feeding the UART; pushes on full are refused, pops on empty ignored.
module memio_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target end of the CPU byte bus: 128KB RAM plus UART/cycle-counter/halt I/O window.
// Define MEMIO_CYCLE_CNT_EN to build the free-running cycle counter and its read snapshot.
module mem_io_responder
  import memio_pkg::*;
#(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  mem_io_responder_if.slave      bus,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   halt,
  output logic                   tx_overflow
);
  localparam int CNT_W = $clog2(TX_DEPTH) + 1;

  logic [7:0]            ram [0:(1<<RAM_ADDR_W)-1];
  logic [RAM_ADDR_W-1:0] ram_addr;
  region_e               region;
  logic [2:0]            io_ofs;
  logic                  is_io, ram_we, uart_rd, uart_wr, halt_wr, cnt_rd;
  logic                  push, tx_full, tx_empty;
  logic [7:0]            push_data, rd_next, cnt_byte;
  logic [CNT_W-1:0]      tx_count;
  logic                  unused_hi;

  assign unused_hi = ^bus.mem_a[31:18];

  assign ram_addr = bus.mem_a[RAM_ADDR_W-1:0];
  assign region   = decode_region(bus.mem_a[17:16]);
  assign io_ofs   = bus.mem_a[2:0];
  assign is_io    = (region == REG_IO);

  // Writes land in the issuing cycle; a reset in that cycle drops them
  assign ram_we  = !rst_in && bus.mem_wr && (region == REG_RAM);
  assign uart_wr = bus.mem_wr && is_io && (io_ofs == IO_UART_OFS);
  assign halt_wr = bus.mem_wr && is_io && (io_ofs == IO_CNT_OFS);
  assign uart_rd = !bus.mem_wr && is_io && (io_ofs == IO_UART_OFS);
  assign cnt_rd  = !bus.mem_wr && is_io && io_ofs[2];

  // Halt write queues a 0x00 end-of-stream marker; plain 0x00 UART writes are ignored
  assign push      = (uart_wr && (bus.mem_wdata != 8'h00)) || halt_wr;
  assign push_data = halt_wr ? 8'h00 : bus.mem_wdata;

  assign rx_ready           = !rst_in && uart_rd && rx_valid;
  assign tx_valid           = !tx_empty;
  assign bus.io_buffer_full = (TX_DEPTH - int'(tx_count)) <= FULL_MARGIN;

  memio_tx_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (push_data),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

`ifdef MEMIO_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:8] cyc_snap;

  // Byte 0 read captures the rest so a 4-byte sweep is tear-free
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_cnt  <= '0;
      cyc_snap <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (cnt_rd && (io_ofs == IO_CNT_OFS)) cyc_snap <= cyc_cnt[31:8];
    end
  end

  always_comb begin
    cnt_byte = cyc_cnt[7:0];
    case (io_ofs[1:0])
      2'd1:    cnt_byte = cyc_snap[15:8];
      2'd2:    cnt_byte = cyc_snap[23:16];
      2'd3:    cnt_byte = cyc_snap[31:24];
      default: cnt_byte = cyc_cnt[7:0];
    endcase
  end
`else
  assign cnt_byte = 8'h00;
`endif

  always_comb begin
    rd_next = 8'h00;
    unique case (region)
      REG_RAM: rd_next = ram[ram_addr];
      REG_IO: begin
        if (io_ofs == IO_UART_OFS) rd_next = rx_valid ? rx_data : 8'h00;
        else if (io_ofs[2])        rd_next = cnt_byte;
      end
      default: rd_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= bus.mem_wdata;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.mem_rdata <= 8'h00;
      halt          <= 1'b0;
      tx_overflow   <= 1'b0;
    end else begin
      if (!bus.mem_wr) bus.mem_rdata <= rd_next;
      if (halt_wr)     halt <= 1'b1;
      if (push && tx_full) tx_overflow <= 1'b1;
    end
  end

endmodule
